// File: rtl/bram_stream_pkg.sv
// rtl/bram_stream_pkg.sv - shared state type and address helpers for bram_stream_reader
package bram_stream_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        CLEAR,
        DRAIN
    } state_e;

    localparam int C_WORD_BYTES = 4;

    // Word-aligned byte address folded into a power-of-two memory.
    function automatic logic [31:0] addr_wrap(input logic [31:0] addr, input logic [31:0] memsize);
        return addr & (memsize - 32'd1) & ~32'(C_WORD_BYTES - 1);
    endfunction

    function automatic logic [31:0] addr_inc(input logic [31:0] addr, input logic [31:0] memsize);
        return addr_wrap(addr + 32'(C_WORD_BYTES), memsize);
    endfunction

endpackage

// File: rtl/bram_stream_fifo2.sv
// rtl/bram_stream_fifo2.sv - 2-entry registered FIFO with simultaneous push and pop
module bram_stream_fifo2
    import bram_stream_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic [DW-1:0] data_i,
    input  logic          pop_i,
    output logic [DW-1:0] data_o,
    output logic          valid_o,
    output logic [1:0]    count_o
);

    logic [DW-1:0] mem_q [2];
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [1:0]    count_q, count_d;

    always_comb begin
        wr_ptr_d = push_i ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d = pop_i  ? ~rd_ptr_q : rd_ptr_q;
        count_d  = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= data_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign valid_o = (count_q != 2'd0);
    assign count_o = count_q;

endmodule

// File: rtl/bram_stream_reader.sv
// rtl/bram_stream_reader.sv - BRAM burst reader feeding a valid/ready stream
// Define BRAM_RD_CLEAR_EN to zero each word after it is read (clear-on-read).
module bram_stream_reader
    import bram_stream_pkg::*;
#(
    parameter int C_MEMSIZE     = 'h4000,
    parameter int C_PORT_DWIDTH = 32,
    parameter int C_PORT_AWIDTH = 32,
    parameter int C_NUM_WE      = 4
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     Start,
    input  logic [31:0]              Base_Addr,
    input  logic [15:0]              Num_Words,
    output logic                     Busy,
    output logic                     Done,
    output logic                     BRAM_Clk,
    output logic                     BRAM_Rst,
    output logic                     BRAM_EN,
    output logic [C_NUM_WE-1:0]      BRAM_WEN,
    output logic [C_PORT_AWIDTH-1:0] BRAM_Addr,
    output logic [C_PORT_DWIDTH-1:0] BRAM_Dout,
    input  logic [C_PORT_DWIDTH-1:0] BRAM_Din,
    output logic [C_PORT_DWIDTH-1:0] M_Data,
    output logic                     M_Valid,
    input  logic                     M_Ready
);

    localparam logic [31:0] MEMSIZE = 32'(C_MEMSIZE);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] left_q, left_d;
    logic        inflight_q;
    logic        done_q, done_d;

    logic        rd_en;
    logic        wr_en;
    logic        pop;
    logic        last_pop;
    logic [1:0]  fifo_count;
    logic [2:0]  occupancy;

    // A pop in the same cycle frees a slot, so back-to-back reads sustain one word per cycle.
    assign pop       = M_Valid & M_Ready;
    assign occupancy = {1'b0, fifo_count} + {2'b0, inflight_q} - {2'b0, pop};

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        left_d   = left_q;
        done_d   = 1'b0;
        rd_en    = 1'b0;
        wr_en    = 1'b0;
        last_pop = 1'b0;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    if (Num_Words == 16'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = READ;
                        addr_d  = addr_wrap(Base_Addr, MEMSIZE);
                        left_d  = Num_Words;
                    end
                end
            end
            READ: begin
                if (occupancy < 3'd2) begin
                    rd_en = 1'b1;
`ifdef BRAM_RD_CLEAR_EN
                    state_d = CLEAR;
`else
                    addr_d = addr_inc(addr_q, MEMSIZE);
                    left_d = left_q - 16'd1;
                    if (left_q == 16'd1) begin
                        state_d = DRAIN;
                    end
`endif
                end
            end
`ifdef BRAM_RD_CLEAR_EN
            // Write zero back to the word read last cycle; the read already latched the old value.
            CLEAR: begin
                wr_en   = 1'b1;
                addr_d  = addr_inc(addr_q, MEMSIZE);
                left_d  = left_q - 16'd1;
                state_d = (left_q == 16'd1) ? DRAIN : READ;
            end
`endif
            DRAIN: begin
                if (pop && (fifo_count == 2'd1) && !inflight_q) begin
                    last_pop = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            left_q     <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            left_q     <= left_d;
            inflight_q <= rd_en;
            done_q     <= done_d;
        end
    end

    bram_stream_fifo2 #(
        .DW(C_PORT_DWIDTH)
    ) u_fifo (
        .clk_i   (Clk),
        .rst_i   (Rst),
        .push_i  (inflight_q),
        .data_i  (BRAM_Din),
        .pop_i   (pop),
        .data_o  (M_Data),
        .valid_o (M_Valid),
        .count_o (fifo_count)
    );

    assign Busy      = (state_q != IDLE);
    assign Done      = done_q | last_pop;
    assign BRAM_Clk  = Clk;
    assign BRAM_Rst  = Rst;
    assign BRAM_EN   = rd_en | wr_en;
    assign BRAM_WEN  = wr_en ? '1 : '0;
    assign BRAM_Addr = C_PORT_AWIDTH'(addr_q);
    assign BRAM_Dout = '0;

endmodule
